// File: rtl/gpu_loader.sv
// Host byte-stream loader for the shader core's external load port: parses command
// packets into one-cycle instruction/data RAM write pulses and owns the core run line.
module gpu_loader #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int WORD_WIDTH    = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic [ADDRESS_WIDTH-1:0] ext_write_address,
    output logic [WORD_WIDTH-1:0]    ext_write_data,
    output logic                     ext_enable_write_inst,
    output logic                     ext_enable_write_data,
    output logic                     run,
    output logic                     busy,
    output logic                     error
);

    localparam logic [7:0] CMD_WRITE_INST = 8'h01;
    localparam logic [7:0] CMD_WRITE_DATA = 8'h02;
    localparam logic [7:0] CMD_RUN        = 8'h03;
    localparam logic [7:0] CMD_STOP       = 8'h04;
    localparam logic [7:0] CMD_CLEAR      = 8'h05;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR0,
        S_ADDR1,
        S_CNT0,
        S_CNT1,
        S_DATA,
        S_WRITE
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       fire;
    logic                       target_inst;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic [15:0]                count;
    logic [1:0]                 byte_index;
    logic [WORD_WIDTH-1:0]      data_buf;

    assign fire = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_CMD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_CMD: begin
                if (fire && (in_data == CMD_WRITE_INST || in_data == CMD_WRITE_DATA)) begin
                    state_next = S_ADDR0;
                end
            end
            S_ADDR0: if (fire) state_next = S_ADDR1;
            S_ADDR1: if (fire) state_next = S_CNT0;
            S_CNT0:  if (fire) state_next = S_CNT1;
            S_CNT1: begin
                if (fire) begin
                    state_next = ({in_data, count[7:0]} == 16'd0) ? S_CMD : S_DATA;
                end
            end
            S_DATA: begin
                if (fire && byte_index == 2'd3) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: state_next = (count == 16'd1) ? S_CMD : S_DATA;
            default: state_next = S_CMD;
        endcase
    end

    // A write command parsed while the core runs still walks through S_WRITE, but pulses nothing.
    always_comb begin
        in_ready              = reset_n && (state != S_WRITE);
        busy                  = (state != S_CMD);
        ext_enable_write_inst = (state == S_WRITE) && !run && target_inst;
        ext_enable_write_data = (state == S_WRITE) && !run && !target_inst;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            target_inst       <= 1'b0;
            address           <= '0;
            count             <= '0;
            byte_index        <= '0;
            data_buf          <= '0;
            ext_write_address <= '0;
            ext_write_data    <= '0;
            run               <= 1'b0;
            error             <= 1'b0;
        end else begin
            if (state == S_WRITE) begin
                address <= address + ADDRESS_WIDTH'(4);
                count   <= count - 16'd1;
            end
            if (fire) begin
                case (state)
                    S_CMD: begin
                        case (in_data)
                            CMD_WRITE_INST: target_inst <= 1'b1;
                            CMD_WRITE_DATA: target_inst <= 1'b0;
                            CMD_RUN:        run         <= 1'b1;
                            CMD_STOP:       run         <= 1'b0;
                            CMD_CLEAR:      error       <= 1'b0;
                            default:        error       <= 1'b1;
                        endcase
                    end
                    S_ADDR0: address <= ADDRESS_WIDTH'({8'h00, in_data});
                    S_ADDR1: address <= ADDRESS_WIDTH'({in_data, address[7:0]});
                    S_CNT0:  count   <= {8'h00, in_data};
                    S_CNT1: begin
                        count      <= {in_data, count[7:0]};
                        byte_index <= 2'd0;
                        if (run) error <= 1'b1;
                    end
                    S_DATA: begin
                        data_buf[{byte_index, 3'b000} +: 8] <= in_data;
                        byte_index <= byte_index + 2'd1;
                        // Outputs move only when a real write is about to be presented.
                        if (byte_index == 2'd3 && !run) begin
                            ext_write_data    <= WORD_WIDTH'({in_data, data_buf[23:0]});
                            ext_write_address <= address;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpu_loader.sv
// Directed bench for gpu_loader: table of single-byte command vectors plus hand-written
// packet sequences, with a negedge monitor that records every write pulse.
module tb_gpu_loader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] ext_write_address;
    logic [31:0] ext_write_data;
    logic        ext_enable_write_inst;
    logic        ext_enable_write_data;
    logic        run;
    logic        busy;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int ready_low = 0;

    typedef struct packed {
        logic        inst;
        logic [15:0] addr;
        logic [31:0] data;
    } pulse_t;

    pulse_t pq[$];

    typedef struct {
        logic [7:0] cmd;
        logic       exp_run;
        logic       exp_error;
        logic       exp_busy;
    } cmd_vec_t;

    gpu_loader #(.ADDRESS_WIDTH(16), .WORD_WIDTH(32)) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .in_valid              (in_valid),
        .in_data               (in_data),
        .in_ready              (in_ready),
        .ext_write_address     (ext_write_address),
        .ext_write_data        (ext_write_data),
        .ext_enable_write_inst (ext_enable_write_inst),
        .ext_enable_write_data (ext_enable_write_data),
        .run                   (run),
        .busy                  (busy),
        .error                 (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (ext_enable_write_inst || ext_enable_write_data) begin
                pq.push_back('{inst: ext_enable_write_inst, addr: ext_write_address, data: ext_write_data});
                check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
                check("single_enable", {31'd0, ext_enable_write_inst & ext_enable_write_data}, 32'd0);
            end
            if (!in_ready) ready_low++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            failures++;
            checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] bytes[], input int max_gap);
        foreach (bytes[i]) send_byte(bytes[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic expect_pulse(input string name, input int i, input logic inst,
                                input logic [15:0] a, input logic [31:0] d);
        if (i < pq.size()) begin
            check({name, "_kind"}, {31'd0, pq[i].inst}, {31'd0, inst});
            check({name, "_addr"}, {16'd0, pq[i].addr}, {16'd0, a});
            check({name, "_data"}, pq[i].data, d);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s_missing: got %0d pulses, expected index %0d", name, pq.size(), i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time 200000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_vec_t vecs[10];
        logic [7:0] seq[];

        vecs[0] = '{8'h03, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h04, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h7E, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h03, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h05, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{8'h04, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{8'h05, 1'b0, 1'b0, 1'b0};

        // Reset state, with in_valid high to show nothing is accepted
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h03;
        idle(3);
        @(negedge clock);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_inst_en", {31'd0, ext_enable_write_inst}, 0);
        check("rst_data_en", {31'd0, ext_enable_write_data}, 0);
        check("rst_addr", {16'd0, ext_write_address}, 0);
        check("rst_data", ext_write_data, 0);
        check("rst_run", {31'd0, run}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_error", {31'd0, error}, 0);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", {31'd0, in_ready}, 1);

        // Single-byte commands
        for (int i = 0; i < 10; i++) begin
            send_byte(vecs[i].cmd, 0);
            check($sformatf("vec%0d_run", i), {31'd0, run}, {31'd0, vecs[i].exp_run});
            check($sformatf("vec%0d_error", i), {31'd0, error}, {31'd0, vecs[i].exp_error});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
        end

        // Back-to-back instruction packet of two words
        pq.delete();
        seq = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00};
        send_seq(seq, 0);
        check("inst_w0_enable_now", {31'd0, ext_enable_write_inst}, 1);
        check("inst_w0_ready_now", {31'd0, in_ready}, 0);
        check("inst_w0_busy", {31'd0, busy}, 1);
        seq = '{8'h73, 8'h00, 8'h10, 8'h00};
        send_seq(seq, 0);
        idle(2);
        check("inst_pulse_count", pq.size(), 2);
        expect_pulse("inst_w0", 0, 1'b1, 16'h0000, 32'h0050_0013);
        expect_pulse("inst_w1", 1, 1'b1, 16'h0004, 32'h0010_0073);
        check("inst_busy_after", {31'd0, busy}, 0);
        check("inst_hold_addr", {16'd0, ext_write_address}, 32'h0004);

        // Data packet wrapping the address
        pq.delete();
        seq = '{8'h02, 8'hFC, 8'hFF, 8'h02, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_seq(seq, 0);
        idle(2);
        check("wrap_pulse_count", pq.size(), 2);
        expect_pulse("wrap_w0", 0, 1'b0, 16'hFFFC, 32'h4433_2211);
        expect_pulse("wrap_w1", 1, 1'b0, 16'h0000, 32'h8877_6655);
        check("wrap_error", {31'd0, error}, 0);

        // Write while running is consumed but suppressed
        pq.delete();
        send_byte(8'h03, 0);
        check("run_set", {31'd0, run}, 1);
        seq = '{8'h01, 8'h00, 8'h00, 8'h01};
        send_seq(seq, 0);
        check("run_err_before_cnthi", {31'd0, error}, 0);
        send_byte(8'h00, 0);
        check("run_err_at_cnthi", {31'd0, error}, 1);
        seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_seq(seq, 0);
        idle(2);
        check("run_pulse_count", pq.size(), 0);
        check("run_data_held", ext_write_data, 32'h8877_6655);
        check("run_busy_after", {31'd0, busy}, 0);
        send_byte(8'h05, 0);
        check("run_err_cleared", {31'd0, error}, 0);
        send_byte(8'h04, 0);
        check("run_cleared", {31'd0, run}, 0);

        // Unknown command, then zero-count packet
        send_byte(8'h7E, 0);
        check("bad_cmd_error", {31'd0, error}, 1);
        check("bad_cmd_busy", {31'd0, busy}, 0);
        seq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(seq, 0);
        check("zero_cnt_busy", {31'd0, busy}, 0);
        idle(2);
        check("zero_cnt_pulses", pq.size(), 0);
        send_byte(8'h05, 0);

        // Three words with random in_valid gaps
        pq.delete();
        ready_low = 0;
        seq = '{8'h01, 8'h10, 8'h00, 8'h03, 8'h00,
                8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0,
                8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_seq(seq, 3);
        idle(3);
        check("gap_pulse_count", pq.size(), 3);
        expect_pulse("gap_w0", 0, 1'b1, 16'h0010, 32'h0403_0201);
        expect_pulse("gap_w1", 1, 1'b1, 16'h0014, 32'hD0C0_B0A0);
        expect_pulse("gap_w2", 2, 1'b1, 16'h0018, 32'hDEAD_BEEF);
        check("gap_ready_low_cycles", ready_low, 3);

        // Reset after six data bytes, then a fresh packet
        seq = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h00,
                8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22};
        send_seq(seq, 0);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        pq.delete();
        @(negedge clock);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_data", ext_write_data, 0);
        seq = '{8'h02, 8'h20, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_seq(seq, 0);
        idle(3);
        check("fresh_pulse_count", pq.size(), 1);
        expect_pulse("fresh_w0", 0, 1'b0, 16'h0020, 32'hEFBE_ADDE);
        check("fresh_busy_after", {31'd0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
